// File: rtl/vga_data_bank_if.sv
// Write/commit/read signal bundle between the control FSM, the display
// pipeline and the VGA data bank.
interface vga_data_bank_if;
    logic       WrReq;
    logic [3:0] WrAddr;
    logic [7:0] WrData;
    logic       WrAck;
    logic       WrErr;
    logic       FrameSync;
    logic [3:0] RdAddr;
    logic [7:0] RdData;
    logic       Pending;

    modport master (
        output WrReq, WrAddr, WrData, FrameSync, RdAddr,
        input  WrAck, WrErr, RdData, Pending
    );

    modport slave (
        input  WrReq, WrAddr, WrData, FrameSync, RdAddr,
        output WrAck, WrErr, RdData, Pending
    );
endinterface

// File: rtl/vga_data_bank.sv
// Double-buffered clock/calendar/chrono register bank: range-checked writes
// land in staging, FrameSync commits the whole bank to the display side.
module vga_data_bank #(
    parameter int unsigned LAST_ADDR  = 12,
    parameter int unsigned CURSOR_MAX = 9
) (
    input logic            CLK,
    input logic            RESET,
    vga_data_bank_if.slave bus
);
    localparam logic [3:0] LAST_A   = (LAST_ADDR > 15) ? 4'd15 : 4'(LAST_ADDR);
    localparam logic [7:0] CURSOR_B = (CURSOR_MAX > 99) ? 8'd99 : 8'(CURSOR_MAX);

    logic [7:0] stage [16];
    logic [7:0] disp  [16];
    logic       addrOk;
    logic       rdOk;
    logic       wrLegal;

    function automatic logic [7:0] maxVal(input logic [3:0] a);
        logic [7:0] m;
        m = '0;
        case (a)
            4'd1, 4'd2, 4'd7, 4'd8: m = 8'd59;
            4'd3, 4'd9:             m = 8'd23;
            4'd4:                   m = 8'd31;
            4'd5:                   m = 8'd12;
            4'd6:                   m = 8'd99;
            4'd10, 4'd11:           m = 8'd1;
            4'd12:                  m = CURSOR_B;
            default:                m = '0;
        endcase
        return m;
    endfunction

    // Day and month are 1-based; they double as the reset contents.
    function automatic logic [7:0] minVal(input logic [3:0] a);
        return (a == 4'd4 || a == 4'd5) ? 8'd1 : 8'd0;
    endfunction

    always_comb begin
        addrOk  = (bus.WrAddr != '0) && (bus.WrAddr <= LAST_A);
        rdOk    = (bus.RdAddr != '0) && (bus.RdAddr <= LAST_A);
        wrLegal = bus.WrReq && addrOk &&
                  (bus.WrData >= minVal(bus.WrAddr)) &&
                  (bus.WrData <= maxVal(bus.WrAddr));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < 16; i++) begin
                stage[i] <= minVal(4'(i));
                disp[i]  <= minVal(4'(i));
            end
            bus.WrAck   <= 1'b0;
            bus.WrErr   <= 1'b0;
            bus.Pending <= 1'b0;
            bus.RdData  <= '0;
        end else begin
            bus.WrAck <= bus.WrReq;
            bus.WrErr <= bus.WrReq && !wrLegal;

            if (wrLegal)
                stage[bus.WrAddr] <= bus.WrData;

            // Commit bypasses staging for a write landing on the same edge.
            if (bus.FrameSync) begin
                for (int unsigned i = 0; i < 16; i++)
                    disp[i] <= (wrLegal && bus.WrAddr == 4'(i)) ? bus.WrData : stage[i];
            end

            if (bus.FrameSync)
                bus.Pending <= 1'b0;
            else if (wrLegal)
                bus.Pending <= 1'b1;

            bus.RdData <= rdOk ? disp[bus.RdAddr] : '0;
        end
    end
endmodule

// File: tb/tb_vga_data_bank.sv
// Directed self-checking bench for vga_data_bank.
module tb_vga_data_bank;
    logic CLK = 1'b0;
    logic RESET;
    int   total = 0;
    int   bad   = 0;

    vga_data_bank_if bus ();

    vga_data_bank #(.LAST_ADDR(12), .CURSOR_MAX(9)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.WrReq     = 1'b0;
        bus.FrameSync = 1'b0;
    endtask

    // One write cycle; checks the ack/err pulse that follows it.
    task automatic issue(input logic [3:0] a, input logic [7:0] d, input logic fs, input logic expErr);
        bus.WrReq     = 1'b1;
        bus.WrAddr    = a;
        bus.WrData    = d;
        bus.FrameSync = fs;
        tick();
        chk($sformatf("ack a%0d d%0d", a, d), {7'd0, bus.WrAck}, 8'd1);
        chk($sformatf("err a%0d d%0d", a, d), {7'd0, bus.WrErr}, {7'd0, expErr});
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] exp);
        bus.RdAddr = a;
        tick();
        chk($sformatf("rd a%0d", a), bus.RdData, exp);
    endtask

    task automatic commit();
        bus.FrameSync = 1'b1;
        tick();
        bus.FrameSync = 1'b0;
    endtask

    logic [7:0] burst [1:12];

    initial begin
        burst = '{8'd59, 8'd0, 8'd12, 8'd31, 8'd12, 8'd99, 8'd30, 8'd15, 8'd23, 8'd1, 8'd1, 8'd9};
        RESET = 1'b1;
        idle();
        bus.WrAddr = '0;
        bus.WrData = '0;
        bus.RdAddr = 4'd4;
        repeat (3) tick();
        chk("rst ack", {7'd0, bus.WrAck}, 8'd0);
        chk("rst pend", {7'd0, bus.Pending}, 8'd0);
        chk("rst rd", bus.RdData, 8'd0);
        RESET = 1'b0;

        rd(4'd4, 8'd1);
        rd(4'd5, 8'd1);
        rd(4'd1, 8'd0);
        chk("pend idle", {7'd0, bus.Pending}, 8'd0);

        // Staged write invisible until commit; read during commit edge sees old value
        issue(4'd1, 8'd45, 1'b0, 1'b0);
        idle();
        chk("pend set", {7'd0, bus.Pending}, 8'd1);
        rd(4'd1, 8'd0);
        chk("ack gone", {7'd0, bus.WrAck}, 8'd0);
        chk("err idle", {7'd0, bus.WrErr}, 8'd0);
        chk("pend hold", {7'd0, bus.Pending}, 8'd1);
        commit();
        chk("rd commit edge", bus.RdData, 8'd0);
        chk("pend clr", {7'd0, bus.Pending}, 8'd0);
        rd(4'd1, 8'd45);

        // Rejected writes, back to back
        issue(4'd2, 8'd60, 1'b0, 1'b1);
        issue(4'd5, 8'd0,  1'b0, 1'b1);
        issue(4'd13, 8'd1, 1'b0, 1'b1);
        issue(4'd0, 8'd0,  1'b0, 1'b1);
        issue(4'd4, 8'd32, 1'b0, 1'b1);
        issue(4'd10, 8'd2, 1'b0, 1'b1);
        issue(4'd12, 8'd10, 1'b0, 1'b1);
        idle();
        tick();
        chk("pend rej", {7'd0, bus.Pending}, 8'd0);
        commit();
        rd(4'd2, 8'd0);
        rd(4'd5, 8'd1);
        rd(4'd4, 8'd1);
        rd(4'd12, 8'd0);

        // Write-through with same-cycle FrameSync
        bus.RdAddr = 4'd3;
        issue(4'd3, 8'd23, 1'b1, 1'b0);
        idle();
        chk("pend bypass", {7'd0, bus.Pending}, 8'd0);
        rd(4'd3, 8'd23);

        // Burst of legal writes at range limits
        for (int a = 1; a <= 12; a++)
            issue(4'(a), burst[a], 1'b0, 1'b0);
        idle();
        chk("pend burst", {7'd0, bus.Pending}, 8'd1);
        rd(4'd6, 8'd0);
        commit();
        for (int a = 1; a <= 12; a++)
            rd(4'(a), burst[a]);
        rd(4'd0, 8'd0);
        rd(4'd13, 8'd0);
        rd(4'd15, 8'd0);

        // Uncommitted write lost to reset; WrReq under reset never acked
        issue(4'd12, 8'd7, 1'b0, 1'b0);
        idle();
        RESET = 1'b1;
        bus.WrReq = 1'b1;
        tick();
        chk("ack in rst", {7'd0, bus.WrAck}, 8'd0);
        tick();
        chk("ack in rst2", {7'd0, bus.WrAck}, 8'd0);
        RESET = 1'b0;
        idle();
        tick();
        chk("ack after rst", {7'd0, bus.WrAck}, 8'd0);
        chk("pend after rst", {7'd0, bus.Pending}, 8'd0);
        rd(4'd12, 8'd0);
        rd(4'd1, 8'd0);
        rd(4'd4, 8'd1);

        // Write in the cycle reset falls is processed
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        issue(4'd6, 8'd42, 1'b0, 1'b0);
        idle();
        chk("pend post rst", {7'd0, bus.Pending}, 8'd1);
        commit();
        rd(4'd6, 8'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
